// File: rtl/guvm_instr_feeder.sv
// Instruction-memory responder for the core fetch port: a driver-filled FIFO answered OBI-style.
// Optional build macro GUVM_FEEDER_STALL_EN: withhold grants while empty instead of returning NOP_INSTR.
module guvm_instr_feeder #(
    parameter int unsigned                         DEPTH             = 8,
    parameter int unsigned                         INSTR_RDATA_WIDTH = 32,
    parameter logic [INSTR_RDATA_WIDTH-1:0]        NOP_INSTR         = 32'h00000013
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              push_valid_i,
    input  logic [INSTR_RDATA_WIDTH-1:0]      push_data_i,
    output logic                              push_ready_o,
    input  logic                              instr_req_i,
    input  logic [31:0]                       instr_addr_i,
    output logic                              instr_gnt_o,
    output logic                              instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0]      instr_rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]        fill_level_o,
    output logic [15:0]                       underflow_cnt_o,
    output logic [31:0]                       last_addr_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [INSTR_RDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]             wptr_q, wptr_d;
    logic [PTR_W-1:0]             rptr_q, rptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         rvalid_q, rvalid_d;
    logic [INSTR_RDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]                  ucnt_q, ucnt_d;
    logic [31:0]                  last_addr_q, last_addr_d;

    logic                         empty_s, full_s;
    logic                         gnt_s, pop_s, push_s, underflow_s;
    logic [INSTR_RDATA_WIDTH-1:0] rsp_word_s;

    // Pointer advance that also handles non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign push_s  = push_valid_i && !full_s && !flush_i;

`ifdef GUVM_FEEDER_STALL_EN
    assign gnt_s       = instr_req_i && !empty_s && !flush_i;
    assign pop_s       = gnt_s;
    assign underflow_s = instr_req_i && empty_s;
`else
    // A grant during flush gets NOP but is deliberately not an underflow.
    assign gnt_s       = instr_req_i;
    assign pop_s       = gnt_s && !empty_s && !flush_i;
    assign underflow_s = gnt_s && empty_s && !flush_i;
`endif

    assign rsp_word_s = pop_s ? mem_q[rptr_q] : NOP_INSTR;

    // Next-state for pointers, occupancy, response and status registers.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rvalid_d    = gnt_s;
        rdata_d     = rdata_q;
        ucnt_d      = ucnt_q;
        last_addr_d = last_addr_q;

        if (flush_i) begin
            wptr_d  = {PTR_W{1'b0}};
            rptr_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_d = ptr_inc(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = ptr_inc(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (gnt_s) begin
            rdata_d     = rsp_word_s;
            last_addr_d = instr_addr_i;
        end else begin
            rdata_d     = rdata_q;
            last_addr_d = last_addr_q;
        end

        if (underflow_s && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // State registers; an in-flight response is dropped by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= {PTR_W{1'b0}};
            rptr_q      <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rvalid_q    <= 1'b0;
            rdata_q     <= {INSTR_RDATA_WIDTH{1'b0}};
            ucnt_q      <= 16'd0;
            last_addr_q <= 32'd0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ucnt_q      <= ucnt_d;
            last_addr_q <= last_addr_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign push_ready_o    = !full_s;
    assign instr_gnt_o     = gnt_s;
    assign instr_rvalid_o  = rvalid_q;
    assign instr_rdata_o   = rdata_q;
    assign fill_level_o    = count_q;
    assign underflow_cnt_o = ucnt_q;
    assign last_addr_o     = last_addr_q;

endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Self-checking bench for guvm_instr_feeder: directed scenarios plus random traffic against a queue model.
module tb_guvm_instr_feeder;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic [31:0] push_data_i = 32'd0;
    logic        push_ready_o;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'd0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic [3:0]  fill_level_o;
    logic [15:0] underflow_cnt_o;
    logic [31:0] last_addr_o;

    guvm_instr_feeder #(.DEPTH(DEPTH), .INSTR_RDATA_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .fill_level_o(fill_level_o), .underflow_cnt_o(underflow_cnt_o), .last_addr_o(last_addr_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef GUVM_FEEDER_STALL_EN
    localparam logic STALL = 1'b1;
`else
    localparam logic STALL = 1'b0;
`endif

    // Reference model: FIFO as a queue, responses computed from the fetch rules.
    logic [31:0] mq[$];
    int          m_ucnt;
    logic [31:0] m_last, m_rdata;
    logic        m_rvalid, m_gnt, m_push_acc, obs_gnt;
    int          vectors = 0;
    int          errors  = 0;

    task automatic drive_cycle(input logic pv, input logic [31:0] pd, input logic rq,
                               input logic [31:0] ad, input logic fl);
        logic empty, full, pop, und;
        logic [31:0] word;
        push_valid_i = pv; push_data_i = pd; instr_req_i = rq; instr_addr_i = ad; flush_i = fl;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        if (STALL) begin
            m_gnt = rq && !empty && !fl;
            und   = rq && empty;
        end else begin
            m_gnt = rq;
            und   = rq && empty && !fl;
        end
        pop        = m_gnt && !empty && !fl;
        word       = pop ? mq[0] : NOP;
        m_push_acc = pv && !full && !fl;
        obs_gnt    = instr_gnt_o;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_push_acc) mq.push_back(pd);
        end
        m_rvalid = m_gnt;
        if (m_gnt) begin
            m_rdata = word;
            m_last  = ad;
        end
        if (und && m_ucnt < 65535) m_ucnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        mq.delete(); m_ucnt = 0; m_last = 32'd0; m_rdata = 32'd0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; flush_i = 1'b0; push_valid_i = 1'b0; instr_req_i = 1'b0;
        push_data_i = 32'd0; instr_addr_i = 32'd0;
        model_clear();
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; push_valid_i = 1'b0; instr_req_i = 1'b0;
        model_clear();
        @(posedge clk_i); #1;
        vectors++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready_o); end
        vectors++; if (instr_rvalid_o !== 1'b0 || instr_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid_gnt got %b%b want 00", instr_rvalid_o, instr_gnt_o); end
        vectors++; if (instr_rdata_o !== 32'd0 || last_addr_o !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", instr_rdata_o, last_addr_o); end
        vectors++; if (fill_level_o !== 4'd0 || underflow_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", fill_level_o, underflow_cnt_o); end
        rst_ni = 1'b1;
        // Reset mid-fetch: the response pending in the rvalid cycle must vanish.
        drive_cycle(1'b1, 32'h002180B3, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b0, 32'd0, 1'b1, 32'h00000040, 1'b0);
        vectors++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL midfetch_rvalid got %b want 1", instr_rvalid_o); end
        instr_req_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL midfetch_reset_rvalid got %b want 0", instr_rvalid_o); end
        vectors++; if (fill_level_o !== 4'd0 || underflow_cnt_o !== 16'd0 || last_addr_o !== 32'd0) begin errors++; $display("FAIL midfetch_reset_state got %0d/%0d/%h want 0/0/0", fill_level_o, underflow_cnt_o, last_addr_o); end
        @(posedge clk_i); #1;
        vectors++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL midfetch_discard got %b want 0", instr_rvalid_o); end
        model_clear();
        rst_ni = 1'b1;
    endtask

    task automatic test_in_order();
        do_reset();
        drive_cycle(1'b1, 32'h002180B3, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b1, 32'h00000533, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b0, 32'd0, 1'b1, 32'h0000000A, 1'b0);
        vectors++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL inorder_gnt1 got %b want 1", obs_gnt); end
        vectors++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h002180B3) begin errors++; $display("FAIL inorder_first got %b/%h want 1/002180b3", instr_rvalid_o, instr_rdata_o); end
        drive_cycle(1'b0, 32'd0, 1'b1, 32'h0000000E, 1'b0);
        vectors++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL inorder_gnt2 got %b want 1", obs_gnt); end
        vectors++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h00000533) begin errors++; $display("FAIL inorder_second got %b/%h want 1/00000533", instr_rvalid_o, instr_rdata_o); end
        vectors++; if (last_addr_o !== 32'h0000000E) begin errors++; $display("FAIL inorder_last_addr got %h want 0000000e", last_addr_o); end
        drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        vectors++; if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h00000533) begin errors++; $display("FAIL inorder_idle_hold got %b/%h want 0/00000533", instr_rvalid_o, instr_rdata_o); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] words [DEPTH+3];
        int np = 0;
        int nd = 0;
        logic rq;
        for (int i = 0; i < DEPTH + 3; i++) words[i] = 32'hA5000000 + 32'(i * 7);
        do_reset();
        for (int c = 0; c < DEPTH + 4 && push_ready_o; c++) begin
            drive_cycle(1'b1, words[np], 1'b0, 32'd0, 1'b0);
            if (m_push_acc) np++;
        end
        vectors++; if (fill_level_o !== 4'(DEPTH) || push_ready_o !== 1'b0) begin errors++; $display("FAIL full_level got %0d/%b want %0d/0", fill_level_o, push_ready_o, DEPTH); end
        drive_cycle(1'b1, words[np], 1'b1, 32'h00000100, 1'b0);
        vectors++; if (fill_level_o !== 4'(DEPTH - 1)) begin errors++; $display("FAIL full_push_refused got %0d want %0d", fill_level_o, DEPTH - 1); end
        vectors++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== words[0]) begin errors++; $display("FAIL full_pop got %b/%h want 1/%h", instr_rvalid_o, instr_rdata_o, words[0]); end
        nd = 1;
        for (int c = 0; c < 100 && nd < DEPTH + 3; c++) begin
            rq = (mq.size() != 0);
            drive_cycle(np < DEPTH + 3, (np < DEPTH + 3) ? words[np] : 32'd0, rq, 32'h00000104 + 32'(4 * c), 1'b0);
            if (m_push_acc) np++;
            if (instr_rvalid_o) begin
                vectors++;
                if (nd >= DEPTH + 3 || instr_rdata_o !== words[nd]) begin
                    errors++; $display("FAIL wrap_order idx %0d got %h want %h", nd, instr_rdata_o, (nd < DEPTH + 3) ? words[nd] : 32'hx);
                end
                nd++;
            end
        end
        vectors++; if (nd != DEPTH + 3) begin errors++; $display("FAIL wrap_delivered got %0d want %0d", nd, DEPTH + 3); end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'd0, 1'b1, 32'h00000200 + 32'(4 * i), 1'b0);
            vectors++; if (obs_gnt !== !STALL) begin errors++; $display("FAIL underflow_gnt got %b want %b", obs_gnt, !STALL); end
            vectors++; if (instr_rvalid_o !== !STALL || (!STALL && instr_rdata_o !== NOP)) begin errors++; $display("FAIL underflow_rsp got %b/%h want %b/%h", instr_rvalid_o, instr_rdata_o, !STALL, NOP); end
        end
        vectors++; if (underflow_cnt_o !== 16'd3) begin errors++; $display("FAIL underflow_cnt got %0d want 3", underflow_cnt_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_cycle(1'b1, 32'h11110001, 1'b1, 32'h00000300, 1'b0);
        vectors++; if (instr_rvalid_o !== !STALL || (!STALL && instr_rdata_o !== NOP)) begin errors++; $display("FAIL simul_nop got %b/%h want %b/%h", instr_rvalid_o, instr_rdata_o, !STALL, NOP); end
        vectors++; if (fill_level_o !== 4'd1) begin errors++; $display("FAIL simul_fill1 got %0d want 1", fill_level_o); end
        drive_cycle(1'b1, 32'h11110002, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b1, 32'h11110003, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b1, 32'h11110004, 1'b1, 32'h00000304, 1'b0);
        vectors++; if (fill_level_o !== 4'd3) begin errors++; $display("FAIL simul_fill3 got %0d want 3", fill_level_o); end
        vectors++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h11110001) begin errors++; $display("FAIL simul_pop got %b/%h want 1/11110001", instr_rvalid_o, instr_rdata_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h22220000 + 32'(i), 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b1, 32'h2222FFFF, 1'b1, 32'h00000400, 1'b1);
        vectors++; if (obs_gnt !== !STALL) begin errors++; $display("FAIL flush_gnt got %b want %b", obs_gnt, !STALL); end
        vectors++; if (instr_rvalid_o !== !STALL || (!STALL && instr_rdata_o !== NOP)) begin errors++; $display("FAIL flush_nop got %b/%h want %b/%h", instr_rvalid_o, instr_rdata_o, !STALL, NOP); end
        vectors++; if (underflow_cnt_o !== 16'd0) begin errors++; $display("FAIL flush_ucnt got %0d want 0", underflow_cnt_o); end
        vectors++; if (fill_level_o !== 4'd0 || push_ready_o !== 1'b1) begin errors++; $display("FAIL flush_fill got %0d/%b want 0/1", fill_level_o, push_ready_o); end
    endtask

    task automatic test_random();
        logic pv, rq, fl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pv = ($urandom_range(0, 3) != 0);
            rq = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 31) == 0);
            drive_cycle(pv, $urandom, rq, $urandom, fl);
            vectors++;
            if (obs_gnt !== m_gnt || instr_rvalid_o !== m_rvalid || instr_rdata_o !== m_rdata ||
                fill_level_o !== 4'(mq.size()) || push_ready_o !== (mq.size() != DEPTH) ||
                underflow_cnt_o !== 16'(m_ucnt) || last_addr_o !== m_last) begin
                errors++;
                $display("FAIL random cyc %0d got gnt%b rv%b rd%h fl%0d rdy%b uc%0d la%h want gnt%b rv%b rd%h fl%0d rdy%b uc%0d la%h",
                         c, obs_gnt, instr_rvalid_o, instr_rdata_o, fill_level_o, push_ready_o, underflow_cnt_o, last_addr_o,
                         m_gnt, m_rvalid, m_rdata, mq.size(), (mq.size() != DEPTH), m_ucnt, m_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_underflow();
        test_simultaneous();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
